// File: rtl/vx_bar_pkg.sv
// Shared configuration, opcode and barrier-table types for the GPU barrier unit.
package vx_bar_pkg;

  localparam int unsigned NUM_WARPS    = 4;
  localparam int unsigned NUM_THREADS  = 4;
  localparam int unsigned NUM_BARRIERS = 4;
  localparam int unsigned UUID_BITS    = 44;
  localparam int unsigned NW_BITS      = $clog2(NUM_WARPS);
  localparam int unsigned NT_BITS      = $clog2(NUM_THREADS);
  localparam int unsigned NB_BITS      = $clog2(NUM_BARRIERS);
  localparam int unsigned CNT_BITS     = NW_BITS + 1;

  localparam logic [2:0] INST_GPU_BAR = 3'h4;

  typedef enum logic {
    IDLE,
    COLLECT
  } bar_state_e;

  typedef struct packed {
    bar_state_e          state;
    logic [CNT_BITS-1:0] count;
    logic [CNT_BITS-1:0] arrived;
    logic [NUM_WARPS-1:0] mask;
  } bar_entry_t;

  function automatic logic [NUM_WARPS-1:0] bar_onehot(input logic [NW_BITS-1:0] wid);
    return NUM_WARPS'(1) << wid;
  endfunction

endpackage

// File: rtl/vx_bar_table.sv
// Barrier table: per-ID arrival tracking with a combinational release decision.
// Optional VX_BAR_PERF_EN exposes a "some entry is collecting" flag.
module vx_bar_table
  import vx_bar_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 arrive,
  input  logic [NB_BITS-1:0]   bar_id,
  input  logic [NW_BITS-1:0]   wid,
  input  logic [CNT_BITS-1:0]  cnt,
  output logic                 release_hit,
  output logic [NUM_WARPS-1:0] release_mask
`ifdef VX_BAR_PERF_EN
  ,
  output logic                 collect_any
`endif
);

  bar_entry_t           entries   [NUM_BARRIERS];
  bar_entry_t           entries_n [NUM_BARRIERS];
  bar_entry_t           cur;
  logic [NUM_WARPS-1:0] onehot;
  logic [CNT_BITS-1:0]  arrived_inc;

  always_comb begin
    entries_n    = entries;
    release_hit  = 1'b0;
    release_mask = '0;
    cur          = entries[bar_id];
    onehot       = bar_onehot(wid);
    arrived_inc  = cur.arrived + CNT_BITS'(1);
    if (arrive) begin
      if (cur.state == IDLE) begin
        if (cnt <= CNT_BITS'(1)) begin
          release_hit  = 1'b1;
          release_mask = onehot;
        end else begin
          entries_n[bar_id] = '{state: COLLECT, count: cnt, arrived: CNT_BITS'(1), mask: onehot};
        end
      end else if ((cur.mask & onehot) == '0) begin
        // Count is latched from the first arrival; later cnt values are ignored.
        if (arrived_inc == cur.count) begin
          release_hit       = 1'b1;
          release_mask      = cur.mask | onehot;
          entries_n[bar_id] = '0;
        end else begin
          entries_n[bar_id].mask    = cur.mask | onehot;
          entries_n[bar_id].arrived = arrived_inc;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_BARRIERS; i++) entries[i] <= '0;
    end else begin
      entries <= entries_n;
    end
  end

`ifdef VX_BAR_PERF_EN
  always_comb begin
    collect_any = 1'b0;
    for (int i = 0; i < NUM_BARRIERS; i++) begin
      if (entries[i].state == COLLECT) collect_any = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/vx_gpu_bar_unit.sv
// GPU barrier unit: accepts GPU ops, tracks BAR arrivals, emits warp releases and commits.
// Define VX_BAR_PERF_EN to add barrier wait-cycle and release counters.
module vx_gpu_bar_unit
  import vx_bar_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        gpu_req_valid,
  input  logic [UUID_BITS-1:0]        gpu_req_uuid,
  input  logic [NW_BITS-1:0]          gpu_req_wid,
  input  logic [NT_BITS-1:0]          gpu_req_tid,
  input  logic [2:0]                  gpu_req_op_type,
  input  logic [NUM_THREADS*32-1:0]   gpu_req_rs1_data,
  input  logic [NUM_THREADS*32-1:0]   gpu_req_rs2_data,
  output logic                        gpu_req_ready,
  output logic                        release_valid,
  output logic [NUM_WARPS-1:0]        release_mask,
  output logic                        commit_valid,
  output logic [UUID_BITS-1:0]        commit_uuid,
  output logic [NW_BITS-1:0]          commit_wid,
  input  logic                        commit_ready
`ifdef VX_BAR_PERF_EN
  ,
  output logic [31:0]                 perf_bar_wait_cycles,
  output logic [31:0]                 perf_bar_releases
`endif
);

  logic                 accept;
  logic                 arrive;
  logic [6:0]           lane_ofs;
  logic [NB_BITS-1:0]   bar_id;
  logic [CNT_BITS-1:0]  cnt_raw;
  logic [CNT_BITS-1:0]  cnt;
  logic                 release_hit;
  logic [NUM_WARPS-1:0] table_mask;

  assign gpu_req_ready = !commit_valid || commit_ready;
  assign accept        = gpu_req_valid && gpu_req_ready;
  assign arrive        = accept && (gpu_req_op_type == INST_GPU_BAR);

  // Operands come from the lane selected by tid.
  assign lane_ofs = {gpu_req_tid, 5'b0};
  assign bar_id   = gpu_req_rs1_data[lane_ofs +: NB_BITS];
  assign cnt_raw  = gpu_req_rs2_data[lane_ofs +: CNT_BITS];
  assign cnt      = (cnt_raw > CNT_BITS'(NUM_WARPS)) ? CNT_BITS'(NUM_WARPS) : cnt_raw;

`ifdef VX_BAR_PERF_EN
  logic collect_any;
`endif

  vx_bar_table u_table (
    .clk          (clk),
    .reset        (reset),
    .arrive       (arrive),
    .bar_id       (bar_id),
    .wid          (gpu_req_wid),
    .cnt          (cnt),
    .release_hit  (release_hit),
    .release_mask (table_mask)
`ifdef VX_BAR_PERF_EN
    ,
    .collect_any  (collect_any)
`endif
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      release_valid <= 1'b0;
      release_mask  <= '0;
      commit_valid  <= 1'b0;
      commit_uuid   <= '0;
      commit_wid    <= '0;
    end else begin
      release_valid <= release_hit;
      release_mask  <= table_mask;
      if (accept) begin
        commit_valid <= 1'b1;
        commit_uuid  <= gpu_req_uuid;
        commit_wid   <= gpu_req_wid;
      end else if (commit_ready) begin
        commit_valid <= 1'b0;
      end
    end
  end

`ifdef VX_BAR_PERF_EN
  // Release counter steps on the same edge release_valid rises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_bar_wait_cycles <= '0;
      perf_bar_releases    <= '0;
    end else begin
      if (collect_any) perf_bar_wait_cycles <= perf_bar_wait_cycles + 32'd1;
      if (release_hit) perf_bar_releases    <= perf_bar_releases + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vx_gpu_bar_unit.sv
// Self-checking bench for vx_gpu_bar_unit: vector table plus backpressure/reset sequences.
module tb_vx_gpu_bar_unit;
  import vx_bar_pkg::*;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      gpu_req_valid;
  logic [UUID_BITS-1:0]      gpu_req_uuid;
  logic [NW_BITS-1:0]        gpu_req_wid;
  logic [NT_BITS-1:0]        gpu_req_tid;
  logic [2:0]                gpu_req_op_type;
  logic [NUM_THREADS*32-1:0] gpu_req_rs1_data;
  logic [NUM_THREADS*32-1:0] gpu_req_rs2_data;
  logic                      gpu_req_ready;
  logic                      release_valid;
  logic [NUM_WARPS-1:0]      release_mask;
  logic                      commit_valid;
  logic [UUID_BITS-1:0]      commit_uuid;
  logic [NW_BITS-1:0]        commit_wid;
  logic                      commit_ready;
`ifdef VX_BAR_PERF_EN
  logic [31:0]               perf_bar_wait_cycles;
  logic [31:0]               perf_bar_releases;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vx_gpu_bar_unit dut (
    .clk              (clk),
    .reset            (reset),
    .gpu_req_valid    (gpu_req_valid),
    .gpu_req_uuid     (gpu_req_uuid),
    .gpu_req_wid      (gpu_req_wid),
    .gpu_req_tid      (gpu_req_tid),
    .gpu_req_op_type  (gpu_req_op_type),
    .gpu_req_rs1_data (gpu_req_rs1_data),
    .gpu_req_rs2_data (gpu_req_rs2_data),
    .gpu_req_ready    (gpu_req_ready),
    .release_valid    (release_valid),
    .release_mask     (release_mask),
    .commit_valid     (commit_valid),
    .commit_uuid      (commit_uuid),
    .commit_wid       (commit_wid),
    .commit_ready     (commit_ready)
`ifdef VX_BAR_PERF_EN
    ,
    .perf_bar_wait_cycles (perf_bar_wait_cycles),
    .perf_bar_releases    (perf_bar_releases)
`endif
  );

  typedef struct {
    logic [1:0]  wid;
    logic [1:0]  tid;
    logic [2:0]  op;
    logic [31:0] bar;
    logic [31:0] cnt;
    logic        rel;
    logic [3:0]  mask;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Non-selected lanes carry all-ones so a wrong lane pick changes bar_id/cnt.
  task automatic drive(input logic v, input logic [1:0] wid, input logic [1:0] tid,
                       input logic [2:0] op, input logic [31:0] bar, input logic [31:0] cnt,
                       input logic [UUID_BITS-1:0] uuid);
    logic [NUM_THREADS*32-1:0] r1;
    logic [NUM_THREADS*32-1:0] r2;
    r1 = '1;
    r2 = '1;
    r1[32*tid +: 32] = bar;
    r2[32*tid +: 32] = cnt;
    gpu_req_valid    = v;
    gpu_req_wid      = wid;
    gpu_req_tid      = tid;
    gpu_req_op_type  = op;
    gpu_req_rs1_data = r1;
    gpu_req_rs2_data = r2;
    gpu_req_uuid     = uuid;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, 2'd0, 3'h0, 32'd0, 32'd0, '0);
  endtask

  initial begin
    logic [UUID_BITS-1:0] uuid;

    vecs[0]  = '{2'd2, 2'd1, INST_GPU_BAR, 32'd1, 32'd1, 1'b1, 4'b0100};
    vecs[1]  = '{2'd0, 2'd0, INST_GPU_BAR, 32'd0, 32'd4, 1'b0, 4'b0000};
    vecs[2]  = '{2'd1, 2'd3, INST_GPU_BAR, 32'd0, 32'd4, 1'b0, 4'b0000};
    vecs[3]  = '{2'd2, 2'd2, INST_GPU_BAR, 32'd0, 32'd4, 1'b0, 4'b0000};
    vecs[4]  = '{2'd3, 2'd0, INST_GPU_BAR, 32'd0, 32'd4, 1'b1, 4'b1111};
    vecs[5]  = '{2'd1, 2'd0, INST_GPU_BAR, 32'd2, 32'd3, 1'b0, 4'b0000};
    vecs[6]  = '{2'd1, 2'd1, INST_GPU_BAR, 32'd2, 32'd3, 1'b0, 4'b0000};
    vecs[7]  = '{2'd0, 2'd2, INST_GPU_BAR, 32'd2, 32'd3, 1'b0, 4'b0000};
    vecs[8]  = '{2'd3, 2'd3, INST_GPU_BAR, 32'd2, 32'd3, 1'b1, 4'b1011};
    vecs[9]  = '{2'd1, 2'd0, 3'h1,         32'd0, 32'd1, 1'b0, 4'b0000};
    vecs[10] = '{2'd0, 2'd1, INST_GPU_BAR, 32'd1, 32'd7, 1'b0, 4'b0000};
    vecs[11] = '{2'd1, 2'd2, INST_GPU_BAR, 32'd1, 32'd2, 1'b0, 4'b0000};
    vecs[12] = '{2'd2, 2'd3, INST_GPU_BAR, 32'd1, 32'd2, 1'b0, 4'b0000};
    vecs[13] = '{2'd3, 2'd0, INST_GPU_BAR, 32'd1, 32'd2, 1'b1, 4'b1111};
    vecs[14] = '{2'd3, 2'd2, INST_GPU_BAR, 32'd3, 32'd0, 1'b1, 4'b1000};
    vecs[15] = '{2'd1, 2'd1, INST_GPU_BAR, 32'd0, 32'd2, 1'b0, 4'b0000};
    vecs[16] = '{2'd2, 2'd3, INST_GPU_BAR, 32'd0, 32'd2, 1'b1, 4'b0110};

    reset        = 1'b1;
    commit_ready = 1'b1;
    idle();
    step();
    step();
    chk("rst_release_valid", 64'(release_valid), 64'd0);
    chk("rst_release_mask",  64'(release_mask),  64'd0);
    chk("rst_commit_valid",  64'(commit_valid),  64'd0);
    chk("rst_commit_uuid",   64'(commit_uuid),   64'd0);
    chk("rst_commit_wid",    64'(commit_wid),    64'd0);
    chk("rst_ready",         64'(gpu_req_ready), 64'd1);
    reset = 1'b0;
    step();

    // Table vectors: one accepted request per cycle, outputs checked one cycle later.
    for (int i = 0; i < 17; i++) begin
      uuid = 44'h5A5_0000_0000 + 44'(i);
      drive(1'b1, vecs[i].wid, vecs[i].tid, vecs[i].op, vecs[i].bar, vecs[i].cnt, uuid);
      step();
      chk($sformatf("v%0d_release_valid", i), 64'(release_valid), 64'(vecs[i].rel));
      chk($sformatf("v%0d_release_mask", i),  64'(release_mask),  64'(vecs[i].mask));
      chk($sformatf("v%0d_commit_valid", i),  64'(commit_valid),  64'd1);
      chk($sformatf("v%0d_commit_uuid", i),   64'(commit_uuid),   64'(uuid));
      chk($sformatf("v%0d_commit_wid", i),    64'(commit_wid),    64'(vecs[i].wid));
    end
    idle();
    step();
    chk("bubble_release_valid", 64'(release_valid), 64'd0);
    chk("bubble_commit_valid",  64'(commit_valid),  64'd0);

    // Backpressure: commit held while consumer stalls, then drain and accept same cycle.
    commit_ready = 1'b0;
    drive(1'b1, 2'd0, 2'd0, 3'h2, 32'd0, 32'd0, 44'h111);
    step();
    chk("bp_commit_valid", 64'(commit_valid), 64'd1);
    chk("bp_commit_uuid",  64'(commit_uuid),  64'h111);
    chk("bp_ready_low",    64'(gpu_req_ready), 64'd0);
    drive(1'b1, 2'd1, 2'd2, INST_GPU_BAR, 32'd1, 32'd1, 44'h222);
    step();
    chk("bp_hold_uuid",    64'(commit_uuid),   64'h111);
    chk("bp_hold_wid",     64'(commit_wid),    64'd0);
    chk("bp_hold_valid",   64'(commit_valid),  64'd1);
    chk("bp_no_release",   64'(release_valid), 64'd0);
    chk("bp_ready_still",  64'(gpu_req_ready), 64'd0);
    commit_ready = 1'b1;
    #1;
    chk("bp_ready_up", 64'(gpu_req_ready), 64'd1);
    step();
    chk("bp_drain_uuid",    64'(commit_uuid),   64'h222);
    chk("bp_drain_wid",     64'(commit_wid),    64'd1);
    chk("bp_drain_release", 64'(release_valid), 64'd1);
    chk("bp_drain_mask",    64'(release_mask),  64'b0010);
    idle();
    step();

    // Mid-collect reset on bar 3, then a fresh cnt=2 barrier must need two arrivals.
    drive(1'b1, 2'd0, 2'd0, INST_GPU_BAR, 32'd3, 32'd3, 44'h301);
    step();
    drive(1'b1, 2'd1, 2'd1, INST_GPU_BAR, 32'd3, 32'd3, 44'h302);
    step();
    chk("mid_commit_valid", 64'(commit_valid), 64'd1);
    idle();
    #1;
    reset = 1'b1;
    #1;
    chk("async_rst_commit_valid", 64'(commit_valid), 64'd0);
    chk("async_rst_commit_uuid",  64'(commit_uuid),  64'd0);
    chk("async_rst_release",      64'(release_valid), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 2'd2, 2'd0, INST_GPU_BAR, 32'd3, 32'd2, 44'h303);
    step();
    chk("post_rst_first_release", 64'(release_valid), 64'd0);
    drive(1'b1, 2'd3, 2'd3, INST_GPU_BAR, 32'd3, 32'd2, 44'h304);
    step();
    chk("post_rst_release", 64'(release_valid), 64'd1);
    chk("post_rst_mask",    64'(release_mask),  64'b1100);
    idle();
    step();
    chk("post_rst_pulse_end", 64'(release_valid), 64'd0);

`ifdef VX_BAR_PERF_EN
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("perf_rst_wait", 64'(perf_bar_wait_cycles), 64'd0);
    chk("perf_rst_rel",  64'(perf_bar_releases),    64'd0);
    drive(1'b1, 2'd0, 2'd0, INST_GPU_BAR, 32'd0, 32'd2, 44'h401);
    step();
    idle();
    for (int k = 0; k < 4; k++) step();
    drive(1'b1, 2'd1, 2'd0, INST_GPU_BAR, 32'd0, 32'd2, 44'h402);
    step();
    idle();
    step();
    step();
    chk("perf_wait", 64'(perf_bar_wait_cycles), 64'd5);
    chk("perf_rel",  64'(perf_bar_releases),    64'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
